// File: rtl/uart_tx.sv
// uart_tx: UART transmit serializer that sits downstream of a baudgen_tx
// bit-rate generator. It accepts one word per start/ready handshake, enables
// the generator through baud_ena, and shifts out
//   start(0), DATA_BITS data bits LSB first, optional parity, STOP_BITS stop(1)
// with one line bit per baud_tick. One further tick after the last stop bit
// closes the frame: ready returns high, done pulses and the generator is
// gated off again.
//
// All outputs are registered. Because baudgen_tx idles at its maximum count,
// the first tick after acceptance arrives two cycles later. That tick drives
// the start bit, so tx falls three cycles after the acceptance cycle.

module uart_tx #(
    parameter int DATA_BITS = 8,   // 5..8
    parameter int PARITY    = 0,   // 0 none, 1 odd, 2 even
    parameter int STOP_BITS = 1    // 1 or 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 baud_tick,
    output logic                 baud_ena,
    output logic                 tx,
    output logic                 ready,
    output logic                 done
);

    // The counter is wide enough for DATA_BITS. It also counts stop bits,
    // and STOP_BITS never exceeds DATA_BITS.
    localparam int CNT_W = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic                 par_q,   par_d;
    logic                 tx_q,    tx_d;
    logic                 ready_q, ready_d;
    logic                 ena_q,   ena_d;
    logic                 done_q,  done_d;

    // A tick only counts while the generator is enabled. A stray pulse while
    // idle must not advance anything.
    logic tick_en;
    assign tick_en = baud_tick && ena_q;

    // Parity bit that completes the word. Odd parity makes the total count
    // of 1s odd, and even parity makes it even.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] w);
        if (PARITY == 1) begin
            return ~^w;
        end
        return ^w;
    endfunction

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        // NOTE: every _d is given its hold value first, so no path through the
        // case statement can leave a variable unassigned and infer a latch.
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        ena_d   = ena_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                ena_d   = 1'b0;
                if (start) begin
                    // Capture the word and its parity now. Later changes on
                    // data cannot corrupt the frame.
                    shift_d = data;
                    par_d   = parity_bit(data);
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    ena_d   = 1'b1;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (tick_en) begin
                    tx_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (tick_en) begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        cnt_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            S_PARITY: begin
                if (tick_en) begin
                    tx_d    = par_q;
                    cnt_d   = '0;
                    state_d = S_STOP;
                end
            end

            S_STOP: begin
                if (tick_en) begin
                    tx_d = 1'b1;
                    if (cnt_q == CNT_W'(STOP_BITS)) begin
                        // The tick after the last stop bit ends the frame.
                        cnt_d   = '0;
                        ena_d   = 1'b0;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers. Reset returns the line to idle immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the shift register is reset as well. It is ordinary
            // datapath state, not a memory array, so the reset is cheap and
            // keeps the block deterministic after an abort.
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            ena_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make all registers update
            // together from the previous cycle's values.
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            ena_q   <= ena_d;
            done_q  <= done_d;
        end
    end

    assign tx       = tx_q;
    assign ready    = ready_q;
    assign baud_ena = ena_q;
    assign done     = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx. Four instances cover 8N1, 8E1,
// 8O1 and 8O2. Each instance is paced by a small baudgen_tx model with
// BAUDRATE=4. The model holds at its maximum count while disabled, so its
// first tick comes one cycle after enable. Expected line bits are queued when
// a word is driven and compared at bit centres.

module tb_uart_tx;

    localparam int B       = 4;    // baud period in clk cycles
    localparam int N       = 4;    // number of DUT configurations
    localparam int TIMEOUT = 200;  // cycle bound on every wait for the DUT

    function automatic int par_of(input int i);
        case (i)
            1:       return 2;
            2:       return 1;
            3:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int stp_of(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    function automatic int nbits_of(input int i);
        return 1 + 8 + ((par_of(i) != 0) ? 1 : 0) + stp_of(i);
    endfunction

    logic         clk = 1'b0;
    logic         rstn;
    logic [N-1:0] start_v;
    logic [N-1:0] tick_v;
    logic [N-1:0] force_tick;
    logic [N-1:0] ena_v;
    logic [N-1:0] tx_v;
    logic [N-1:0] ready_v;
    logic [N-1:0] done_v;
    logic [7:0]   data_v [N];

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        int bcnt;

        // baudgen_tx model: holds at B-1 while disabled and wraps 0..B-1 while enabled.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)            bcnt <= B - 1;
            else if (!ena_v[g])   bcnt <= B - 1;
            else if (bcnt == B-1) bcnt <= 0;
            else                  bcnt <= bcnt + 1;
        end

        assign tick_v[g] = (ena_v[g] && bcnt == 0) || force_tick[g];

        uart_tx #(
            .DATA_BITS(8),
            .PARITY   (par_of(g)),
            .STOP_BITS(stp_of(g))
        ) u_dut (
            .clk      (clk),
            .rstn     (rstn),
            .start    (start_v[g]),
            .data     (data_v[g]),
            .baud_tick(tick_v[g]),
            .baud_ena (ena_v[g]),
            .tx       (tx_v[g]),
            .ready    (ready_v[g]),
            .done     (done_v[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected line bits for one frame on instance idx.
    task automatic push_frame(input int idx, input logic [7:0] w);
        sb_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) sb_q.push_back(w[i]);
        if (par_of(idx) == 1) sb_q.push_back(~^w);
        if (par_of(idx) == 2) sb_q.push_back(^w);
        for (int s = 0; s < stp_of(idx); s++) sb_q.push_back(1'b1);
    endtask

    // Called at a negedge in cycle t. It drives start and returns at the negedge of t+1.
    task automatic accept(input int idx, input logic [7:0] w, output int t);
        t            = cyc;
        start_v[idx] = 1'b1;
        data_v[idx]  = w;
        push_frame(idx, w);
        @(negedge clk);
        check("acc_ready", ready_v[idx], 1'b0);
        check("acc_ena", ena_v[idx], 1'b1);
    endtask

    // Finds the start bit, compares each bit centre with the scoreboard, then
    // checks the done pulse. When abort_bits>0, it returns right after
    // sampling that many bits.
    task automatic monitor_frame(input int idx, input int abort_bits,
                                 output int fall_c, output int done_c);
        int   guard;
        bit   rdy_hi;
        logic exp_b;
        guard  = 0;
        rdy_hi = 1'b0;
        fall_c = -1;
        done_c = -1;
        while (tx_v[idx] !== 1'b0 && guard < TIMEOUT) begin
            @(negedge clk);
            guard++;
            if (ready_v[idx] !== 1'b0 && tx_v[idx] !== 1'b0) rdy_hi = 1'b1;
        end
        if (guard >= TIMEOUT) begin
            check("fall_timeout", 1, 0);
            return;
        end
        fall_c = cyc;
        for (int k = 0; k < nbits_of(idx); k++) begin
            if (abort_bits > 0 && k == abort_bits) return;
            while (cyc < fall_c + k * B + B / 2) begin
                @(negedge clk);
                if (ready_v[idx] !== 1'b0) rdy_hi = 1'b1;
            end
            if (sb_q.size() == 0) begin
                check("sb_empty", 1, 0);
            end else begin
                exp_b = sb_q.pop_front();
                check($sformatf("bit%0d", k), tx_v[idx], exp_b);
            end
        end
        guard = 0;
        while (done_v[idx] !== 1'b1 && guard < TIMEOUT) begin
            @(negedge clk);
            guard++;
            if (ready_v[idx] !== 1'b0 && done_v[idx] !== 1'b1) rdy_hi = 1'b1;
        end
        if (guard >= TIMEOUT) begin
            check("done_timeout", 1, 0);
            return;
        end
        done_c = cyc;
        check("ready_low", rdy_hi, 1'b0);
        check("end_ready", ready_v[idx], 1'b1);
        check("end_ena", ena_v[idx], 1'b0);
        check("end_tx", tx_v[idx], 1'b1);
        @(negedge clk);
        check("done_pulse", done_v[idx], 1'b0);
    endtask

    task automatic run_frame(input int idx, input logic [7:0] w);
        int t, f, d;
        accept(idx, w, t);
        start_v[idx] = 1'b0;
        data_v[idx]  = ~w;  // changing data after acceptance must not matter
        monitor_frame(idx, 0, f, d);
        check("fall_lat", f - t, 3);
        check("frame_len", d - f, nbits_of(idx) * B);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, f, d, f2, d2;
        rstn       = 1'b0;
        start_v    = '0;
        force_tick = '0;
        for (int i = 0; i < N; i++) data_v[i] = 8'h00;

        repeat (2) @(negedge clk);
        check("rst_tx", tx_v, {N{1'b1}});
        check("rst_ready", ready_v, {N{1'b1}});
        check("rst_ena", ena_v, '0);
        check("rst_done", done_v, '0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // A stray tick while idle must not move the line.
        force_tick[0] = 1'b1;
        @(negedge clk);
        force_tick[0] = 1'b0;
        check("idle_tick_tx", tx_v[0], 1'b1);
        check("idle_tick_ready", ready_v[0], 1'b1);
        check("idle_tick_ena", ena_v[0], 1'b0);
        @(negedge clk);

        // The 8N1 frame for 0x55 alternates on every bit.
        run_frame(0, 8'h55);
        // Check the parity bit for each parity type, then a two-stop-bit frame.
        run_frame(1, 8'h03);
        run_frame(2, 8'h03);
        run_frame(3, 8'h00);
        for (int i = 0; i < 3; i++) begin
            run_frame(0, 8'($urandom_range(0, 255)));
            run_frame(1, 8'($urandom_range(0, 255)));
        end

        // Back-to-back with start held: 0xA5 then 0x3C, plus an ignored 0xFF pulse.
        accept(0, 8'hA5, t);
        push_frame(0, 8'h3C);
        data_v[0] = 8'h3C;
        monitor_frame(0, 0, f, d);
        check("b2b_fall1", f - t, 3);
        start_v[0] = 1'b0;
        fork
            monitor_frame(0, 0, f2, d2);
            begin
                repeat (20) @(negedge clk);
                data_v[0]  = 8'hFF;
                start_v[0] = 1'b1;
                @(negedge clk);
                start_v[0] = 1'b0;
            end
        join
        // Second acceptance happens in the done cycle, and its start bit comes 3 cycles later.
        check("b2b_gap", f2 - d, 3);
        check("b2b_len", d2 - f2, 10 * B);
        repeat (10) @(negedge clk);
        check("no_queue_tx", tx_v[0], 1'b1);
        check("no_queue_ready", ready_v[0], 1'b1);

        // Abort during data bit 4 of 0x0F, then send a clean frame.
        accept(0, 8'h0F, t);
        start_v[0] = 1'b0;
        monitor_frame(0, 6, f, d);
        rstn = 1'b0;
        #1;
        check("abort_tx", tx_v[0], 1'b1);
        check("abort_ready", ready_v[0], 1'b1);
        check("abort_ena", ena_v[0], 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        sb_q.delete();
        @(negedge clk);
        run_frame(0, 8'h81);

        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
